sel_index_walker: RTL

- Upstream feeder for the runtime bit-select stage.
- Accepts one load command: a WIDTH-bit data word, a signed start index, an element count and a step direction.
- Walks the index sequence one element per accepted handshake and presents each index with the held word and an out-of-range flag.
- The downstream selector consumes the word and index; it never has to range-check, because this block flags every index outside 0..WIDTH-1, including negative ones.

---
 rtl/sel_index_walker.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sel_index_walker.sv
// Walks a signed index over a held word, one element per out handshake, flagging indices outside 0..WIDTH-1.
// First element appears the cycle after the load; out_* hold while out_ready=0; SEL_WALK_BIT_EN registers out_bit=word[index].
module sel_index_walker #(
  parameter int WIDTH  = 44,
  parameter int IDX_W  = 8,
  parameter int OOBC_W = 8
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WIDTH-1:0]  load_word,
  input  logic [IDX_W-1:0]  load_start,
  input  logic [IDX_W-1:0]  load_count,
  input  logic              load_down,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_word,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_oob,
  output logic              out_last,
  output logic              out_bit,
  output logic [OOBC_W-1:0] oob_cnt
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic signed [IDX_W:0] WIDTH_S = WIDTH[IDX_W:0];

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_word;
  logic [IDX_W-1:0]    r_index;
  logic [IDX_W-1:0]    r_remaining;
  logic                r_down;
  logic [OOBC_W-1:0]   r_oob_cnt;

  logic                w_load_acc;
  logic                w_hs;
  logic                w_last;
  logic [IDX_W-1:0]    w_step_idx;
  logic [IDX_W-1:0]    w_nxt_idx;
  logic [WIDTH-1:0]    w_nxt_word;

  // Sign-extend by one bit so an index of e.g. -1 never aliases to a large unsigned value.
  function automatic logic f_oob(input logic [IDX_W-1:0] idx);
    logic signed [IDX_W:0] s;
    s = $signed({idx[IDX_W-1], idx});
    return (s < 0) || (s >= WIDTH_S);
  endfunction

  assign w_load_acc = load_valid && load_ready;
  assign w_hs       = out_valid && out_ready;
  assign w_last     = (r_remaining == {{(IDX_W-1){1'b0}}, 1'b1});
  assign w_step_idx = r_down ? (r_index - 1'b1) : (r_index + 1'b1);

  always_comb begin
    w_nxt_idx  = r_index;
    w_nxt_word = r_word;
    if (w_load_acc) begin
      w_nxt_idx  = load_start;
      w_nxt_word = load_word;
    end else if (w_hs && !w_last) begin
      w_nxt_idx  = w_step_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_load_acc && (load_count != '0)) w_state_nxt = RUN;
      RUN:  if (w_hs && w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_word      <= '0;
      r_index     <= '0;
      r_remaining <= '0;
      r_down      <= 1'b0;
      r_oob_cnt   <= '0;
    end else begin
      r_word  <= w_nxt_word;
      r_index <= w_nxt_idx;
      if (w_load_acc) begin
        r_remaining <= load_count;
        r_down      <= load_down;
        r_oob_cnt   <= '0;
      end else if (w_hs) begin
        if (!w_last) r_remaining <= r_remaining - 1'b1;
        if (out_oob && (r_oob_cnt != '1)) r_oob_cnt <= r_oob_cnt + 1'b1;
      end
    end
  end

`ifdef SEL_WALK_BIT_EN
  logic r_bit;

  function automatic logic f_bit(input logic [WIDTH-1:0] word, input logic [IDX_W-1:0] idx);
    logic [WIDTH-1:0] sh;
    sh = word >> idx;
    return f_oob(idx) ? 1'b0 : sh[0];
  endfunction

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_bit <= 1'b0;
    end else begin
      r_bit <= f_bit(w_nxt_word, w_nxt_idx);
    end
  end

  assign out_bit = r_bit;
`else
  assign out_bit = 1'b0;
`endif

  assign load_ready = (r_state == IDLE);
  assign out_valid  = (r_state == RUN);
  assign out_word   = r_word;
  assign out_index  = r_index;
  assign out_oob    = f_oob(r_index);
  assign out_last   = (r_state == RUN) && w_last;
  assign oob_cnt    = r_oob_cnt;

endmodule
